// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared constants and helpers for the MEM pipeline stage:
//               access-size encodings, data-path width, byte-lane count and
//               the misaligned-access predicate.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int DATA_W     = 32;
  localparam int BYTE_LANES = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Size 2'b11 behaves as a word, so any size with bit 1 set needs
  // word alignment. Byte accesses can never be misaligned.
  function automatic logic misalign_chk(
    input logic       rd,
    input logic       wr,
    input logic [1:0] size,
    input logic [1:0] addr_lo
  );
    logic w_half;
    logic w_word;
    w_half = (size == SZ_HALF);
    w_word = size[1];
    return (rd | wr) & ((w_half & addr_lo[0]) | (w_word & (addr_lo != 2'b00)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_byte_ram.sv
`default_nettype none
// ============================================================================
// Module      : mem_byte_ram
// Description : Word-organised data RAM with per-byte write enables and an
//               asynchronous (combinational) read port. Contents are not
//               reset.
// Ports       : clk   - write clock, rising edge
//               addr  - word index
//               we    - byte-lane write enables (lane n = bits 8n+7:8n)
//               wdata - write data, lanes already positioned
//               rdata - word at addr (pre-write value in the write cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_byte_ram
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [BYTE_LANES-1:0] we,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int c_DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] r_mem [0:c_DEPTH-1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTE_LANES; i++) begin
      if (we[i]) begin
        r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/mem_stage_bhw.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_bhw
// Description : MIPS MEM pipeline stage with byte/half/word stores, sign- or
//               zero-extended loads, misalignment detection and the MEM/WB
//               pipeline register (flush beats stall).
// Ports       : clk, rst_n (async active-low)
//               in_address, in_write_data, in_mem_read, in_mem_write,
//               in_size, in_load_unsigned, in_write_back, in_mem_to_reg,
//               in_rd, in_stall, in_flush              - from EX/MEM
//               read_data, address_out, write_back_out, mem_to_reg,
//               rd_out, misalign_out                   - registered, to WB
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_bhw
  import mem_pkg::*;
#(
  parameter int DATA_W     = mem_pkg::DATA_W,
  parameter int DEPTH_LOG2 = 10,
  parameter int REG_W      = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_address,
  input  logic [DATA_W-1:0] in_write_data,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [1:0]        in_size,
  input  logic              in_load_unsigned,
  input  logic              in_write_back,
  input  logic              in_mem_to_reg,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_stall,
  input  logic              in_flush,
  output logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] address_out,
  output logic              write_back_out,
  output logic              mem_to_reg,
  output logic [REG_W-1:0]  rd_out,
  output logic              misalign_out
);

  logic                  w_misalign;
  logic                  w_store_en;
  logic [BYTE_LANES-1:0] w_be;
  logic [BYTE_LANES-1:0] w_we;
  logic [DATA_W-1:0]     w_wdata;
  logic [DATA_W-1:0]     w_rword;
  logic [DATA_W-1:0]     w_load;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;

  assign w_misalign = misalign_chk(in_mem_read, in_mem_write, in_size, in_address[1:0]);

  // rst_n in the enable drops a store whose edge arrives while reset is held.
  assign w_store_en = in_mem_write & ~w_misalign & ~in_stall & ~in_flush & rst_n;
  assign w_we       = w_store_en ? w_be : '0;

  // Store data is replicated across lanes so the byte enables alone pick
  // which lanes change.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = in_write_data;
    case (in_size)
      SZ_BYTE: begin
        w_be    = 4'b0001 << in_address[1:0];
        w_wdata = {4{in_write_data[7:0]}};
      end
      SZ_HALF: begin
        w_be    = in_address[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{in_write_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = in_write_data;
      end
    endcase
  end

  mem_byte_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .addr  (in_address[2 +: DEPTH_LOG2]),
    .we    (w_we),
    .wdata (w_wdata),
    .rdata (w_rword)
  );

  assign w_byte = w_rword[8*in_address[1:0] +: 8];
  assign w_half = w_rword[16*in_address[1] +: 16];

  always_comb begin
    w_load = '0;
    if (in_mem_read) begin
      case (in_size)
        SZ_BYTE: w_load = {{24{w_byte[7] & ~in_load_unsigned}}, w_byte};
        SZ_HALF: w_load = {{16{w_half[15] & ~in_load_unsigned}}, w_half};
        default: w_load = w_rword;
      endcase
    end
  end

  // MEM/WB register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data      <= '0;
      address_out    <= '0;
      write_back_out <= 1'b0;
      mem_to_reg     <= 1'b0;
      rd_out         <= '0;
      misalign_out   <= 1'b0;
    end else if (in_flush) begin
      read_data      <= '0;
      address_out    <= '0;
      write_back_out <= 1'b0;
      mem_to_reg     <= 1'b0;
      rd_out         <= '0;
      misalign_out   <= 1'b0;
    end else if (!in_stall) begin
      read_data      <= w_load;
      address_out    <= in_address;
      write_back_out <= in_write_back & ~w_misalign;
      mem_to_reg     <= in_mem_to_reg;
      rd_out         <= in_rd;
      misalign_out   <= w_misalign;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_bhw.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_bhw
// Description : Self-checking bench for mem_stage_bhw. A byte-addressed
//               reference memory and expected MEM/WB values are kept in the
//               bench; directed steps are followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_bhw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_address;
  logic [31:0] in_write_data;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [1:0]  in_size;
  logic        in_load_unsigned;
  logic        in_write_back;
  logic        in_mem_to_reg;
  logic [4:0]  in_rd;
  logic        in_stall;
  logic        in_flush;
  logic [31:0] read_data;
  logic [31:0] address_out;
  logic        write_back_out;
  logic        mem_to_reg;
  logic [4:0]  rd_out;
  logic        misalign_out;

  always #5 clk = ~clk;

  mem_stage_bhw #(
    .DATA_W     (32),
    .DEPTH_LOG2 (10),
    .REG_W      (5)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_address       (in_address),
    .in_write_data    (in_write_data),
    .in_mem_read      (in_mem_read),
    .in_mem_write     (in_mem_write),
    .in_size          (in_size),
    .in_load_unsigned (in_load_unsigned),
    .in_write_back    (in_write_back),
    .in_mem_to_reg    (in_mem_to_reg),
    .in_rd            (in_rd),
    .in_stall         (in_stall),
    .in_flush         (in_flush),
    .read_data        (read_data),
    .address_out      (address_out),
    .write_back_out   (write_back_out),
    .mem_to_reg       (mem_to_reg),
    .rd_out           (rd_out),
    .misalign_out     (misalign_out)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference: 4 KiB byte memory, indexed by the low 12 address bits.
  logic [7:0]  m [0:4095];
  logic [31:0] e_rdata, e_addr;
  logic        e_wb, e_m2r, e_mis;
  logic [4:0]  e_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
      $error("%s observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic ref_mis(input logic rd, input logic wr, input logic [1:0] size,
                                   input logic [31:0] a);
    if (!(rd || wr)) return 1'b0;
    if (size == 2'd0) return 1'b0;
    if (size == 2'd1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                           input logic uns);
    int a;
    int base;
    logic [7:0]  b;
    logic [15:0] h;
    a = int'(addr % 4096);
    if (size == 2'd0) begin
      b = m[a];
      return (uns || b < 8'h80) ? {24'h0, b} : {24'hFFFFFF, b};
    end else if (size == 2'd1) begin
      base = (a / 2) * 2;
      h = {m[base+1], m[base]};
      return (uns || h < 16'h8000) ? {16'h0, h} : {16'hFFFF, h};
    end
    base = (a / 4) * 4;
    return {m[base+3], m[base+2], m[base+1], m[base]};
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] d);
    int a;
    int n;
    int base;
    a = int'(addr % 4096);
    if (size == 2'd0) begin
      n = 1; base = a;
    end else if (size == 2'd1) begin
      n = 2; base = (a / 2) * 2;
    end else begin
      n = 4; base = (a / 4) * 4;
    end
    for (int i = 0; i < n; i++) m[base+i] = d[8*i +: 8];
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".read_data"},   read_data,              e_rdata);
    chk({tag, ".address_out"}, address_out,            e_addr);
    chk({tag, ".wb"},          {31'b0, write_back_out}, {31'b0, e_wb});
    chk({tag, ".m2r"},         {31'b0, mem_to_reg},     {31'b0, e_m2r});
    chk({tag, ".rd"},          {27'b0, rd_out},         {27'b0, e_rd});
    chk({tag, ".misalign"},    {31'b0, misalign_out},   {31'b0, e_mis});
  endtask

  // One clock: drive at negedge, predict, clock, update model, check at negedge.
  task automatic step(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                      input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                      input logic wb, input logic m2r, input logic [4:0] rdi,
                      input logic stall, input logic flush);
    logic mis;
    in_address = addr; in_write_data = wd; in_mem_read = rd; in_mem_write = wr;
    in_size = size; in_load_unsigned = uns; in_write_back = wb; in_mem_to_reg = m2r;
    in_rd = rdi; in_stall = stall; in_flush = flush;
    mis = ref_mis(rd, wr, size, addr);
    if (flush) begin
      e_rdata = 0; e_addr = 0; e_wb = 0; e_m2r = 0; e_rd = 0; e_mis = 0;
    end else if (!stall) begin
      e_rdata = rd ? ref_load(addr, size, uns) : 32'h0;
      e_addr  = addr;
      e_wb    = wb && !mis;
      e_m2r   = m2r;
      e_rd    = rdi;
      e_mis   = mis;
    end
    @(posedge clk);
    if (wr && !mis && !stall && !flush) ref_store(addr, size, wd);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) m[i] = 8'h00;
    rst_n = 1'b0;
    in_address = 0; in_write_data = 0; in_mem_read = 0; in_mem_write = 0;
    in_size = 0; in_load_unsigned = 0; in_write_back = 0; in_mem_to_reg = 0;
    in_rd = 0; in_stall = 0; in_flush = 0;
    e_rdata = 0; e_addr = 0; e_wb = 0; e_m2r = 0; e_rd = 0; e_mis = 0;
    #3;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Known contents for the test window (words 0..15).
    for (int i = 0; i < 16; i++) step("init", i * 4, 32'h0, 0, 1, 2'b10, 0, 0, 0, 0, 0, 0);

    // Word store then load
    step("st_w",  32'h10, 32'hDEADBEEF, 0, 1, 2'b10, 0, 0, 0, 5'd0, 0, 0);
    step("ld_w",  32'h10, 32'h0,        1, 0, 2'b10, 0, 1, 1, 5'd3, 0, 0);
    chk("ld_w_const", read_data, 32'hDEADBEEF);
    chk("ld_w_wb", {31'b0, write_back_out}, 32'd1);
    chk("ld_w_mis", {31'b0, misalign_out}, 32'd0);

    // Byte store and extension
    step("clr_w", 32'h10, 32'h0,  0, 1, 2'b10, 0, 0, 0, 5'd0, 0, 0);
    step("st_b",  32'h13, 32'h80, 0, 1, 2'b00, 0, 0, 0, 5'd0, 0, 0);
    step("ld_bs", 32'h13, 32'h0,  1, 0, 2'b00, 0, 1, 1, 5'd4, 0, 0);
    chk("ld_bs_const", read_data, 32'hFFFFFF80);
    step("ld_bu", 32'h13, 32'h0,  1, 0, 2'b00, 1, 1, 1, 5'd5, 0, 0);
    chk("ld_bu_const", read_data, 32'h00000080);
    step("ld_bw", 32'h10, 32'h0,  1, 0, 2'b10, 0, 1, 1, 5'd6, 0, 0);
    chk("ld_bw_const", read_data, 32'h80000000);

    // Half store, misaligned half store
    step("st_h",  32'h22, 32'hFFFF1234, 0, 1, 2'b01, 0, 0, 0, 5'd0, 0, 0);
    step("ld_hu", 32'h22, 32'h0,        1, 0, 2'b01, 1, 1, 1, 5'd7, 0, 0);
    chk("ld_hu_const", read_data, 32'h00001234);
    step("st_hm", 32'h21, 32'hAAAA,     0, 1, 2'b01, 0, 1, 0, 5'd8, 0, 0);
    chk("st_hm_mis", {31'b0, misalign_out}, 32'd1);
    chk("st_hm_wb", {31'b0, write_back_out}, 32'd0);
    step("ld_h20", 32'h20, 32'h0,       1, 0, 2'b10, 0, 1, 1, 5'd9, 0, 0);
    chk("ld_h20_const", read_data, 32'h12340000);

    // Stall holds, store under stall dropped, flush beats stall
    step("ld_10",  32'h10, 32'h0,      1, 0, 2'b10, 0, 1, 1, 5'd10, 0, 0);
    step("stall1", 32'h20, 32'h0,      1, 0, 2'b10, 0, 1, 0, 5'd11, 1, 0);
    step("stall2", 32'h24, 32'h0,      1, 0, 2'b10, 0, 0, 0, 5'd12, 1, 0);
    chk("stall_hold", read_data, 32'h80000000);
    step("st_stl", 32'h30, 32'h5555,  0, 1, 2'b10, 0, 0, 0, 5'd0, 1, 0);
    step("ld_30",  32'h30, 32'h0,      1, 0, 2'b10, 0, 1, 1, 5'd13, 0, 0);
    chk("ld_30_const", read_data, 32'h0);
    step("flush",  32'h10, 32'h0,      1, 0, 2'b10, 0, 1, 1, 5'd14, 1, 1);
    chk("flush_rd", read_data, 32'h0);
    chk("flush_addr", address_out, 32'h0);

    // Aliasing: 0x1004 wraps to word 1
    step("st_al", 32'h1004, 32'hA5A50001, 0, 1, 2'b10, 0, 0, 0, 5'd0, 0, 0);
    step("ld_al", 32'h4,    32'h0,        1, 0, 2'b10, 0, 1, 1, 5'd15, 0, 0);
    chk("ld_al_const", read_data, 32'hA5A50001);

    // Reset asserted mid-store
    step("st_8", 32'h8, 32'h11112222, 0, 1, 2'b10, 0, 0, 0, 5'd0, 0, 0);
    step("ld_8", 32'h8, 32'h0,        1, 0, 2'b10, 0, 1, 1, 5'd16, 0, 0);
    in_address = 32'h8; in_write_data = 32'hCAFEF00D; in_mem_read = 0; in_mem_write = 1;
    in_size = 2'b10; in_write_back = 1; in_rd = 5'd17; in_stall = 0; in_flush = 0;
    #2 rst_n = 1'b0;
    #1;
    e_rdata = 0; e_addr = 0; e_wb = 0; e_m2r = 0; e_rd = 0; e_mis = 0;
    check_all("rst_async");
    @(posedge clk);
    @(negedge clk);
    in_mem_write = 0;
    rst_n = 1'b1;
    step("ld_8r", 32'h8, 32'h0, 1, 0, 2'b10, 0, 1, 1, 5'd18, 0, 0);
    chk("ld_8r_const", read_data, 32'h11112222);

    // Random traffic inside the initialised window, with random alias bits
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      logic        rd, wr, st, fl;
      a  = ($urandom & 32'hFFFF_F000) | $urandom_range(0, 63);
      sz = 2'($urandom_range(0, 3));
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 9) == 0);
      step("rand", a, $urandom, rd, wr, sz, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           st, fl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage_bhw.md
Name: mem_stage_bhw

Overview:
- Parametrised successor to the MIPS MEM pipeline stage.
- Holds a word-organised data RAM with byte/half/word stores, and sign- or zero-extended byte/half/word loads.
- Detects misaligned accesses and folds in the MEM/WB pipeline register, with stall and flush.
- Sits between EX/MEM and the write-back mux; feeds WB and the forwarding unit.

Parameters:
- DATA_W, 32: data path width. Fixed at 32 for lane logic; the parameter exists for the package constant.
- DEPTH_LOG2, 10: log2 of the RAM depth in words (1024 words = 4 KiB).
- REG_W, 5: destination register index width.

Ports:
- clk  in  1  stage clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_address  in  32  byte address from ALU.
- in_write_data  in  32  store data (rt), right-aligned.
- in_mem_read  in  1  load request.
- in_mem_write  in  1  store request.
- in_size  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- in_load_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
- in_write_back  in  1  register write enable from EX/MEM.
- in_mem_to_reg  in  1  WB select: memory vs ALU.
- in_rd  in  REG_W  destination register.
- in_stall  in  1  hold MEM/WB and suppress the store.
- in_flush  in  1  insert a bubble into MEM/WB.
- read_data  out  32  registered, extended load data.
- address_out  out  32  registered ALU result / address.
- write_back_out  out  1  registered write enable.
- mem_to_reg  out  1  registered WB select.
- rd_out  out  REG_W  registered destination.
- misalign_out  out  1  registered misaligned-access flag.

Behaviour:
- **Reset.** While rst_n = 0, all registered outputs are 0, asynchronously, and RAM writes are suppressed. RAM contents are not reset.
- **RAM geometry.** Word index = in_address[2 +: DEPTH_LOG2]. Higher address bits are ignored, so accesses wrap modulo the RAM size.
- **RAM read.** Combinational from the array and only meaningful when in_mem_read = 1. A load in the same cycle as a store to the same word returns the old data. The new data is visible the following cycle.
- **Misalignment.**
  - misalign = (in_mem_read | in_mem_write) & ((size == half & addr[0]) | (size ∈ {word, 11} & addr[1:0] != 0)).
  - Byte accesses are never misaligned.
- **Store.** At posedge clk, when in_mem_write & !misalign & !in_stall & !in_flush & rst_n:
  - byte: write in_write_data[7:0] into lane addr[1:0].
  - half: write in_write_data[15:0] into lanes {addr[1],0}.
  - word: write all four lanes.
  - Lane n = bits 8n+7:8n (little-endian). Other lanes are untouched.
- **Load extraction.**
  - byte: select lane addr[1:0].
  - half: select bits 16·addr[1] +: 16.
  - Extend to 32 bits: sign-extend when in_load_unsigned = 0, zero-extend when 1.
  - Word loads ignore in_load_unsigned.
  - When in_mem_read = 0, the read_data next value is 0.
- **MEM/WB register, per rising edge (priority in this order):**
  1. in_flush = 1: all outputs load 0 (bubble). Flush beats stall.
  2. in_stall = 1: all outputs hold their values.
  3. Otherwise: load the next values.
     - read_data = extracted load data.
     - address_out = in_address.
     - write_back_out = in_write_back & !misalign.
     - mem_to_reg = in_mem_to_reg.
     - rd_out = in_rd.
     - misalign_out = misalign.
- **Latency.** One cycle from inputs to the registered outputs.
- **Simultaneous events.** in_mem_read & in_mem_write together: the store executes and the load returns pre-store data.
- **Reset mid-operation.** A store pending at the edge where rst_n falls is dropped. Outputs clear immediately.

Decomposition:
- **Package mem_pkg:**
  - size encodings SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10.
  - DATA_W = 32, BYTE_LANES = 4.
  - A function computing the misalign condition.
- **Sub-module mem_byte_ram:**
  - DEPTH_LOG2-parameterised.
  - 4-bit byte-enable write port, combinational read.
- Lane select/extend logic and the MEM/WB register stay in the top module.

Test Plan:
- Word store 0xDEADBEEF at 0x10, then word load 0x10 next cycle -> read_data = 0xDEADBEEF one cycle after the load; write_back_out = 1; misalign_out = 0.
- Byte store 0x80 at 0x13 over 0x00000000, then signed byte load at 0x13 -> 0xFFFFFF80. Unsigned byte load -> 0x00000080. Word load at 0x10 -> 0x80000000.
- Half store 0x1234 at 0x22, then unsigned half load 0x22 -> 0x00001234. Half store at 0x21 -> misalign_out = 1, write_back_out = 0, and a word load of 0x20 shows the RAM unchanged.
- Word load at 0x10 with in_stall = 1 for 2 cycles -> outputs hold the previous values. A store issued under stall does not modify RAM. Flush + stall together -> all outputs 0.
- Address 0x1000 + 4 (DEPTH_LOG2 = 10) -> aliases to word 1, so a store there is visible at address 0x4.
- rst_n pulsed low mid-store -> outputs 0 asynchronously and the stored word is unchanged after reset release.
